apb_led_pwm: RTL and testbench
==============================

# apb_led_pwm

APB3 slave peripheral that drives a parametrised bank of LED outputs, each with an independent PWM brightness level, plus a shared global enable and a global blink mode. It sits on the fabric APB3 bus next to the other memory-mapped I/O blocks. It replaces static on/off LED drive with per-channel duty control generated from a programmable prescaler.

## Interface
- NUM_LEDS, 24, number of LED channels (1..48)
- PWM_BITS, 8, duty/PWM counter width (1..16); PWM frame = 2^PWM_BITS ticks
- PRESCALE_BITS, 16, prescaler register width (1..32)
- PCLK  in  1  clock
- PRESET  in  1  reset, synchronous, active-high
- PSEL  in  1  peripheral select
- PENABLE  in  1  access phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  32  byte address; only PADDR[7:0] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  tied 1 (zero wait states)
- PSLVERR  out  1  error on unmapped access
- LED  out  NUM_LEDS  LED drive, registered, 1 = on

## Operation
- Register map (word aligned, PADDR[1:0] ignored):
  - 0x00 CTRL rw: bit0 EN (global enable), bit1 BLINK_EN; other bits read 0
  - 0x04 PRESCALE rw [PRESCALE_BITS-1:0]: one PWM tick every PRESCALE+1 clocks
  - 0x08 BLINK rw [15:0]: blink phase toggles every BLINK+1 PWM frames
  - 0x0C STATUS ro: [15:0] frame counter (wraps at 0xFFFF), [16] blink phase
  - 0x40 + 4*i DUTY[i] rw [PWM_BITS-1:0], i = 0..NUM_LEDS-1
- Any other address (incl. DUTY slots >= NUM_LEDS, write to STATUS) is unmapped.
- Write commits when PSEL & PENABLE & PWRITE, at that PCLK edge. Unused upper bits of PWDATA dropped.
- Read: PRDATA combinational from PADDR when PSEL & !PWRITE, zero-extended; 0 otherwise and 0 for unmapped.
- PSLVERR = PSEL & PENABLE & unmapped; unmapped writes have no effect.
- Datapath:
  - presc_cnt counts 0..PRESCALE; tick when presc_cnt == PRESCALE, then presc_cnt <= 0.
  - pwm_cnt (PWM_BITS) increments on tick, wraps 2^PWM_BITS-1 -> 0; wrap = end of frame.
  - frame_cnt increments at each frame end; blink_cnt counts frames 0..BLINK, on reaching BLINK at frame end: blink_cnt <= 0, phase toggles.
  - LED[i] <= EN & (DUTY[i] > pwm_cnt) & (!BLINK_EN | phase).
- EN = 0: presc_cnt, pwm_cnt, blink_cnt, frame_cnt held at 0, phase held 1, LED = 0.
- BLINK_EN = 0: blink_cnt and phase held (0, 1); frame_cnt still runs.

## Timing
- Reset: all registers 0, PRESCALE 0, BLINK 0, all counters 0, phase 1, LED 0, PRDATA 0 (no PSEL), PSLVERR 0, PREADY 1.
- PRESET mid-frame: everything returns to reset values at that edge; bus access in same cycle is dropped.
- LED lags pwm_cnt by one clock (registered compare). DUTY/CTRL write at edge T affects LED from edge T+1.
- Write to PRESCALE: presc_cnt <= 0 at the same edge (no overshoot when shrinking). Write to BLINK: blink_cnt <= 0 at the same edge.
- DUTY = 0: LED never on. DUTY = 2^PWM_BITS-1: off for exactly one tick per frame.
- Frame length = (PRESCALE+1) * 2^PWM_BITS clocks; blink half-period = (BLINK+1) frames.
- Tick and write to PRESCALE in same cycle: write wins, presc_cnt <= 0, pwm_cnt still increments for that tick.
- EN 0->1 write at edge T: first tick at T+PRESCALE+1.

## Test plan
- Reset, read all mapped regs -> 0 except STATUS = 0x0001_0000; LED = 0; PSLVERR = 0.
- EN=1, PRESCALE=0, DUTY[3]=64 -> LED[3] high exactly 64 of every 256 clocks, others 0; DUTY[5]=255 -> LED[5] low 1 of 256 clocks.
- PRESCALE=3, DUTY[0]=128 -> frame = 1024 clocks, LED[0] high 512 contiguous clocks; STATUS[15:0] increments every 1024 clocks.
- BLINK_EN=1, BLINK=1, PRESCALE=0, DUTY[0]=255 -> LED[0] PWM-active 512 clocks, forced 0 next 512, repeating; STATUS[16] toggles every 512 clocks.
- Read 0x30 and write 0x40+4*24 (NUM_LEDS=24) -> PSLVERR=1 in access phase, PRDATA=0, no register changes.
- Mid-frame PRESET pulse with EN=1 -> next cycle all regs 0, LED=0, counters 0; write PRESCALE while presc_cnt=5 of 9 -> presc_cnt 0 next cycle.

Source files
------------

// File: rtl/apb_led_pwm.sv
// apb_led_pwm: APB3 slave driving a bank of PWM-dimmed LED outputs.
// Per-channel duty registers are compared against a shared PWM counter that
// advances once per prescaler tick; a global enable gates everything and an
// optional blink mode masks all LEDs on alternating groups of PWM frames.
//
// Bus handshake: a transfer is a setup cycle (PSEL & !PENABLE) followed by one
// access cycle (PSEL & PENABLE). PREADY is constant 1, so every access cycle
// completes; a write commits at the PCLK edge that ends its access cycle.
// PRDATA is combinational from PADDR whenever PSEL & !PWRITE, and PSLVERR flags
// an access-phase cycle that hits an unmapped address (unmapped writes are dropped).
module apb_led_pwm #(
    parameter int NUM_LEDS      = 24,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [31:0]         PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    output logic [NUM_LEDS-1:0] LED
);

    // Word indices (PADDR[7:2]) of the register map.
    localparam logic [5:0] IDX_CTRL     = 6'd0;
    localparam logic [5:0] IDX_PRESCALE = 6'd1;
    localparam logic [5:0] IDX_BLINK    = 6'd2;
    localparam logic [5:0] IDX_STATUS   = 6'd3;
    localparam logic [5:0] IDX_DUTY     = 6'd16;
    localparam logic [6:0] DUTY_END     = 7'(16 + NUM_LEDS);

    localparam logic [PRESCALE_BITS-1:0] PRESC_ONE = 1;
    localparam logic [PWM_BITS-1:0]      PWM_ONE   = 1;
    localparam logic [PWM_BITS-1:0]      PWM_LAST  = '1;

    // Programmable state
    logic                     en;
    logic                     blink_en;
    logic [PRESCALE_BITS-1:0] prescale;
    logic [15:0]              blink_reload;
    logic [PWM_BITS-1:0]      duty [NUM_LEDS];

    // Datapath counters
    logic [PRESCALE_BITS-1:0] presc_cnt;
    logic [PWM_BITS-1:0]      pwm_cnt;
    logic [15:0]              frame_cnt;
    logic [15:0]              blink_cnt;
    logic                     phase;

    // Decode
    logic [5:0]  word_idx;
    logic [5:0]  duty_off;
    logic        is_duty;
    logic        rd_hit;
    logic        wr_hit;
    logic [31:0] rd_data;
    logic        unmapped;
    logic        access;
    logic        wr_en;
    logic        presc_wr;
    logic        blink_wr;
    logic        ctrl_wr;
    logic        tick;
    logic        frame_end;

    assign word_idx = PADDR[7:2];
    assign duty_off = word_idx - IDX_DUTY;
    assign is_duty  = ({1'b0, word_idx} >= 7'd16) && ({1'b0, word_idx} < DUTY_END);

    // Read mux: zero for anything unmapped.
    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        case (word_idx)
            IDX_CTRL: begin
                rd_data = {30'd0, blink_en, en};
                rd_hit  = 1'b1;
            end
            IDX_PRESCALE: begin
                rd_data = 32'(prescale);
                rd_hit  = 1'b1;
            end
            IDX_BLINK: begin
                rd_data = {16'd0, blink_reload};
                rd_hit  = 1'b1;
            end
            IDX_STATUS: begin
                rd_data = {15'd0, phase, frame_cnt};
                rd_hit  = 1'b1;
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (is_duty && (duty_off == 6'(i))) begin
                rd_data = 32'(duty[i]);
                rd_hit  = 1'b1;
            end
        end
    end

    // STATUS is read-only, so it is not a write target.
    assign wr_hit   = (word_idx == IDX_CTRL) || (word_idx == IDX_PRESCALE) ||
                      (word_idx == IDX_BLINK) || is_duty;
    assign unmapped = PWRITE ? !wr_hit : !rd_hit;
    assign access   = PSEL && PENABLE;
    assign wr_en    = access && PWRITE && wr_hit;
    assign ctrl_wr  = wr_en && (word_idx == IDX_CTRL);
    assign presc_wr = wr_en && (word_idx == IDX_PRESCALE);
    assign blink_wr = wr_en && (word_idx == IDX_BLINK);

    assign PRDATA  = (PSEL && !PWRITE) ? rd_data : 32'd0;
    assign PREADY  = 1'b1;
    assign PSLVERR = access && unmapped;

    assign tick      = en && (presc_cnt == prescale);
    assign frame_end = tick && (pwm_cnt == PWM_LAST);

    // Register file writes; reset wins over a same-cycle bus access.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            en           <= 1'b0;
            blink_en     <= 1'b0;
            prescale     <= '0;
            blink_reload <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty[i] <= '0;
            end
        end else begin
            if (ctrl_wr) begin
                en       <= PWDATA[0];
                blink_en <= PWDATA[1];
            end
            if (presc_wr) begin
                prescale <= PWDATA[PRESCALE_BITS-1:0];
            end
            if (blink_wr) begin
                blink_reload <= PWDATA[15:0];
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_en && is_duty && (duty_off == 6'(i))) begin
                    duty[i] <= PWDATA[PWM_BITS-1:0];
                end
            end
        end
    end

    // Prescaler, PWM and frame counters; a PRESCALE write restarts the
    // prescaler but a tick landing on that edge still advances the PWM counter.
    always_ff @(posedge PCLK) begin
        if (PRESET || !en) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            if (presc_wr || tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_ONE;
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_ONE;
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Blink phase: toggles after every BLINK+1 frame ends. A BLINK write
    // restarts the frame count; a toggle due on that same edge still happens.
    always_ff @(posedge PCLK) begin
        if (PRESET || !en || !blink_en) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            if (frame_end && (blink_cnt == blink_reload)) begin
                phase <= ~phase;
            end
            if (blink_wr) begin
                blink_cnt <= '0;
            end else if (frame_end) begin
                blink_cnt <= (blink_cnt == blink_reload) ? 16'd0 : blink_cnt + 16'd1;
            end
        end
    end

    // Registered LED compare, one clock behind the PWM counter.
    always_ff @(posedge PCLK) begin
        if (PRESET || !en) begin
            LED <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                LED[i] <= (duty[i] > pwm_cnt) && (!blink_en || phase);
            end
        end
    end

endmodule

// File: tb/tb_apb_led_pwm.sv
// tb_apb_led_pwm: randomized APB traffic against apb_led_pwm, checked by a
// reference model that derives counter state from elapsed clocks since the
// last restart point, plus directed duty/prescale/blink/unmapped/reset cases.
module tb_apb_led_pwm;

    localparam int NUM_LEDS      = 24;
    localparam int PWM_BITS      = 8;
    localparam int PRESCALE_BITS = 16;
    localparam longint FRAME     = 64'd1 << PWM_BITS;

    // ---------------- clock / reset ----------------
    logic                PCLK = 1'b0;
    logic                PRESET;
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [31:0]         PADDR;
    logic [31:0]         PWDATA;
    logic [31:0]         PRDATA;
    logic                PREADY;
    logic                PSLVERR;
    logic [NUM_LEDS-1:0] LED;

    always #5 PCLK = ~PCLK;

    longint cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    apb_led_pwm #(
        .NUM_LEDS(NUM_LEDS),
        .PWM_BITS(PWM_BITS),
        .PRESCALE_BITS(PRESCALE_BITS)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR),
        .LED(LED)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Ticks since restart = base + elapsed clocks / (PRESCALE+1); frames and
    // PWM position follow from that; blink phase from frames since its restart.
    bit     m_en, m_be, m_ph0;
    longint m_p, m_b, m_base, m_t0, m_bfr0;
    int     m_duty [NUM_LEDS];

    function automatic longint m_ticks(input longint c);
        return m_base + (c - m_t0) / (m_p + 1);
    endfunction

    function automatic longint m_frames(input longint c);
        return m_ticks(c) / FRAME;
    endfunction

    function automatic bit m_phase(input longint c);
        if (!m_en || !m_be) return 1'b1;
        return m_ph0 ^ ((((m_frames(c) - m_bfr0) / (m_b + 1)) % 2) == 1);
    endfunction

    function automatic logic [NUM_LEDS-1:0] m_led(input longint c);
        logic [NUM_LEDS-1:0] r = '0;
        longint pw;
        if (!m_en) return '0;
        if (m_be && !m_phase(c)) return '0;
        pw = m_ticks(c) % FRAME;
        for (int i = 0; i < NUM_LEDS; i++) r[i] = (m_duty[i] > pw);
        return r;
    endfunction

    function automatic bit m_unmapped(input logic [31:0] a, input bit wr);
        int idx = int'(a[7:2]);
        if (idx >= 16 && idx < 16 + NUM_LEDS) return 1'b0;
        if (wr) return idx > 2;
        return idx > 3;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input longint c);
        int idx = int'(a[7:2]);
        if (idx >= 16 && idx < 16 + NUM_LEDS) return 32'(m_duty[idx-16]);
        case (idx)
            0: return {30'd0, m_be, m_en};
            1: return 32'(m_p);
            2: return 32'(m_b);
            3: begin
                if (!m_en) return 32'h0001_0000;
                return {15'd0, m_phase(c), 16'(m_frames(c) % 65536)};
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_en = 0; m_be = 0; m_p = 0; m_b = 0;
        m_base = 0; m_t0 = 0; m_bfr0 = 0; m_ph0 = 1;
        for (int i = 0; i < NUM_LEDS; i++) m_duty[i] = 0;
    endtask

    // Apply a committed write at edge c.
    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input longint c);
        int idx = int'(a[7:2]);
        if (idx >= 16 && idx < 16 + NUM_LEDS) begin
            m_duty[idx-16] = int'(d % FRAME);
        end else if (idx == 0) begin
            if (d[0] && !m_en) begin
                m_base = 0; m_t0 = c; m_bfr0 = 0; m_ph0 = 1;
            end else if (d[0] && m_en && d[1] && !m_be) begin
                m_bfr0 = m_frames(c); m_ph0 = 1;
            end
            m_en = d[0];
            m_be = d[1];
        end else if (idx == 1) begin
            if (m_en) begin
                m_base = m_ticks(c); m_t0 = c;
            end
            m_p = longint'(d) % (64'd1 << PRESCALE_BITS);
        end else if (idx == 2) begin
            if (m_en && m_be) begin
                m_ph0 = m_phase(c); m_bfr0 = m_frames(c);
            end
            m_b = longint'(d[15:0]);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [32:0]         exp_q[$];
    logic [32:0]         mon_exp;
    logic [NUM_LEDS-1:0] led_pred = '0;
    bit                  mon_on = 0;

    always @(negedge PCLK) begin
        if (mon_on) begin
            if (PSEL && PENABLE) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL apb_resp: access phase with nothing expected at cycle %0d", cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({PSLVERR, PRDATA} !== mon_exp || PREADY !== 1'b1) begin
                        errors++;
                        $display("FAIL apb_resp: cycle %0d addr %h got err=%b data=%h ready=%b expected err=%b data=%h ready=1",
                                 cyc, PADDR, PSLVERR, PRDATA, PREADY, mon_exp[32], mon_exp[31:0]);
                    end
                end
            end else if (!PSEL) begin
                checks++;
                if (PRDATA !== 32'd0 || PSLVERR !== 1'b0) begin
                    errors++;
                    $display("FAIL apb_idle: cycle %0d got data=%h err=%b expected data=0 err=0", cyc, PRDATA, PSLVERR);
                end
            end
            checks++;
            if (LED !== led_pred) begin
                errors++;
                $display("FAIL led: cycle %0d got %h expected %h", cyc, LED, led_pred);
            end
        end
        led_pred = PRESET ? '0 : m_led(cyc);
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] mk_addr(input int base);
        logic [31:0] r = $urandom();
        return {r[31:8], 8'(base)} | 32'($urandom_range(0, 3));
    endfunction

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        bit err;
        err = m_unmapped(a, 1'b1);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1;
        exp_q.push_back({err, 32'd0});
        @(posedge PCLK); #1;
        if (!err) m_write(a, d, cyc);
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [31:0] a);
        bit err;
        err = m_unmapped(a, 1'b0);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a; PWDATA = $urandom();
        @(posedge PCLK); #1;
        PENABLE = 1;
        exp_q.push_back({err, err ? 32'd0 : m_read(a, cyc)});
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    // Write access whose completing edge coincides with a reset pulse.
    task automatic reset_during_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1; PRESET = 1;
        exp_q.push_back({m_unmapped(a, 1'b1), 32'd0});
        @(posedge PCLK); #1;
        m_reset();
        PRESET = 0; PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic count_led(input int idx, input int len, output int cnt);
        cnt = 0;
        repeat (len) begin
            @(negedge PCLK);
            if (LED[idx]) cnt++;
        end
        #1;
    endtask

    task automatic check_val(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic read_all_ctrl();
        apb_read(32'h00); apb_read(32'h04); apb_read(32'h08); apb_read(32'h0C);
        apb_read(32'h40); apb_read(32'h40 + 4 * (NUM_LEDS - 1));
    endtask

    // ---------------- stimulus ----------------
    int cnt;

    initial begin
        PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        m_reset();
        repeat (2) @(posedge PCLK);
        #1 mon_on = 1;
        @(posedge PCLK); #1;
        PRESET = 0;

        // Reset values
        read_all_ctrl();

        // Plain PWM, prescale 0
        apb_write(32'h40 + 4 * 3, 32'd64);
        apb_write(32'h40 + 4 * 5, 32'd255);
        apb_write(32'h00, 32'h1);
        idle(10);
        count_led(3, 256, cnt); check_val("led3_duty64_per_256", cnt, 64);
        count_led(5, 256, cnt); check_val("led5_duty255_per_256", cnt, 255);
        apb_read(32'h0C);

        // Prescale 3, frame of 1024 clocks
        apb_write(32'h00, 32'h0);
        apb_write(32'h04, 32'd3);
        apb_write(32'h40, 32'd128);
        apb_write(32'h00, 32'h1);
        idle(10);
        count_led(0, 1024, cnt); check_val("led0_duty128_per_frame", cnt, 512);
        apb_read(32'h0C);
        idle(1021);
        apb_read(32'h0C);

        // Blink, BLINK=1
        apb_write(32'h00, 32'h0);
        apb_write(32'h04, 32'd0);
        apb_write(32'h08, 32'd1);
        apb_write(32'h40, 32'd255);
        apb_write(32'h00, 32'h3);
        idle(10);
        count_led(0, 1024, cnt); check_val("led0_blink_per_1024", cnt, 510);
        apb_read(32'h0C);
        idle(300);
        apb_read(32'h0C);

        // Unmapped and aliased addresses
        apb_read(32'h30);
        apb_write(32'h40 + 4 * NUM_LEDS, 32'hFF);
        apb_write(32'h0C, 32'hFFFF_FFFF);
        apb_write(32'h44, 32'hFFFF_FF21);
        apb_read(32'hFC);
        apb_read(32'h0000_0100);
        apb_read(32'h44);
        read_all_ctrl();

        // Shrink PRESCALE while the prescaler is at 5 of 9
        apb_write(32'h00, 32'h0);
        apb_write(32'h04, 32'd9);
        apb_write(32'h4C, 32'd100);
        apb_write(32'h00, 32'h1);
        for (int k = 0; k < 20 && ((cyc + 2 - m_t0) % 10) != 5; k++) idle(1);
        apb_write(32'h04, 32'd4);
        idle(600);
        apb_read(32'h0C);

        // Reset pulse mid-frame with a colliding write
        reset_during_write(32'h04, 32'd5);
        read_all_ctrl();

        // Randomized traffic
        for (int r = 0; r < 6; r++) begin
            apb_write(32'h00, 32'h0);
            apb_write(mk_addr(4), ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 2));
            apb_write(mk_addr(8), $urandom_range(0, 2));
            for (int i = 0; i < NUM_LEDS; i++) begin
                case ($urandom_range(0, 3))
                    0: apb_write(mk_addr(64 + 4 * i), 32'd0);
                    1: apb_write(mk_addr(64 + 4 * i), 32'hFFFF_FFFF);
                    default: apb_write(mk_addr(64 + 4 * i), $urandom());
                endcase
            end
            apb_write(mk_addr(0), ($urandom() & 32'hFFFF_FFFC) | 32'(($urandom_range(0, 1) << 1) | 1));
            for (int k = 0; k < 25; k++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: idle($urandom_range(5, 120));
                    3, 4: apb_read(mk_addr(4 * $urandom_range(0, 63)));
                    5: apb_write(mk_addr(64 + 4 * $urandom_range(0, NUM_LEDS - 1)), $urandom());
                    6: begin
                        case ($urandom_range(0, 2))
                            0: apb_write(mk_addr(12), $urandom());
                            1: apb_write(mk_addr(16 + 4 * $urandom_range(0, 11)), $urandom());
                            default: apb_write(mk_addr(64 + 4 * $urandom_range(NUM_LEDS, 47)), $urandom());
                        endcase
                    end
                    7: apb_write(mk_addr(4), ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 2));
                    8: apb_write(mk_addr(8), ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 2));
                    default: apb_write(mk_addr(0), ($urandom() & 32'hFFFF_FFFC) |
                                       32'(($urandom_range(0, 1) << 1) | ($urandom_range(0, 3) != 0)));
                endcase
            end
            read_all_ctrl();
        end

        // Drain
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge PCLK);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses never observed, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time
    initial begin
        #800000;
        checks++;
        errors++;
        $display("FAIL watchdog: run still active at cycle %0d, expected completion earlier", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
